sm2_mult_seq: RTL



---
 rtl/sm2_mult_seq.sv | 72 +++++++
 1 files changed

// File: rtl/sm2_mult_seq.sv
// sm2_mult_seq: digit-serial schoolbook WIDTH x WIDTH multiplier, one DIGIT x DIGIT product per cycle,
// with valid/ready handshakes on operands and product.
module sm2_mult_seq #(
  parameter int WIDTH = 256,
  parameter int DIGIT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);
  localparam int ND = WIDTH / DIGIT;
  localparam int IW = ND > 1 ? $clog2(ND) : 1;
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2;
  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2*WIDTH-1:0] r_acc, r_p;
  logic [IW-1:0]      r_i, r_j;
  logic [DIGIT-1:0]   w_da, w_db;
  logic [2*DIGIT-1:0] w_pp;
  logic [31:0]        w_sh;
  logic [2*WIDTH-1:0] w_acc;
  logic               w_last_j, w_last;
  // The only multiplier in the design: one digit of a times one digit of b.
  assign w_da     = r_a[32'(r_i)*DIGIT +: DIGIT];
  assign w_db     = r_b[32'(r_j)*DIGIT +: DIGIT];
  assign w_pp     = w_da * w_db;
  assign w_sh     = DIGIT * (32'(r_i) + 32'(r_j));
  assign w_acc    = r_acc + ((2*WIDTH)'(w_pp) << w_sh);
  assign w_last_j = r_j == IW'(ND-1);
  assign w_last   = w_last_j && r_i == IW'(ND-1);
  assign in_ready  = r_state == IDLE;
  assign busy      = r_state == MUL;
  assign out_valid = r_state == DONE;
  assign p         = r_p;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_p     <= '0;
      r_i     <= '0;
      r_j     <= '0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_a     <= a;
        r_b     <= b;
        r_acc   <= '0;
        r_i     <= '0;
        r_j     <= '0;
        r_state <= MUL;
      end
    end else if (r_state == MUL) begin
      r_acc <= w_acc;
      r_j   <= w_last_j ? '0 : r_j + 1'b1;
      r_i   <= w_last_j ? r_i + 1'b1 : r_i;
      if (w_last) begin
        r_p     <= w_acc;
        r_state <= DONE;
      end
    end else begin
      r_state <= (r_state == DONE && !out_ready) ? DONE : IDLE;
    end
  end
endmodule
